// File: rtl/resp_reorder.sv
// ============================================================================
// Module   : resp_reorder
// Purpose  : Restores arrival order of sorted memory responses by slot tag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module resp_reorder #(
    parameter int ENTRY_W = 12,
    parameter int TAG_W   = 4,
    parameter int DATA_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [TAG_W:0]     batch_len_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [ENTRY_W-1:0] in_entry_i,
    input  logic [DATA_W-1:0]  in_data_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [ENTRY_W-1:0] out_entry_o,
    output logic [DATA_W-1:0]  out_data_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    localparam int               DEPTH      = 2**TAG_W;
    localparam logic [TAG_W:0]   C_LEN_ONE  = {{TAG_W{1'b0}}, 1'b1};
    localparam logic [TAG_W-1:0] C_PTR_ONE  = {{(TAG_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t             state_q;
    logic [DEPTH-1:0]   occ_q;
    logic [ENTRY_W-1:0] entry_q [DEPTH];
    logic [DATA_W-1:0]  data_q  [DEPTH];
    logic [TAG_W-1:0]   rd_ptr_q;
    logic [TAG_W:0]     len_q;
    logic               done_q;
    logic               err_q;

    logic               w_active;
    logic [TAG_W-1:0]   w_tag;
    logic               w_accept;
    logic               w_store;
    logic               w_drop;
    logic               w_xfer;
    logic               w_last;

    always_comb begin
        w_active = (state_q == ACTIVE);
        w_tag    = in_entry_i[TAG_W-1:0];
        w_accept = in_valid_i & w_active;
        // Occupancy is checked before this edge's transfer clears its slot,
        // so a response aimed at the slot being released counts as a duplicate.
        w_store  = w_accept & ({1'b0, w_tag} < len_q) & ~occ_q[w_tag];
        w_drop   = w_accept & ~w_store;
        w_xfer   = out_valid_o & out_ready_i;
        w_last   = ({1'b0, rd_ptr_q} == (len_q - C_LEN_ONE));
    end

    assign in_ready_o  = w_active;
    assign out_valid_o = w_active & occ_q[rd_ptr_q];
    assign out_entry_o = entry_q[rd_ptr_q];
    assign out_data_o  = data_q[rd_ptr_q];
    assign busy_o      = w_active;
    assign done_o      = done_q;
    assign err_o       = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            occ_q    <= '0;
            rd_ptr_q <= '0;
            len_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (batch_len_i == '0) begin
                            err_q <= 1'b1;
                        end else begin
                            state_q  <= ACTIVE;
                            len_q    <= batch_len_i;
                            rd_ptr_q <= '0;
                            occ_q    <= '0;
                        end
                    end
                end
                ACTIVE: begin
                    if (w_xfer) begin
                        occ_q[rd_ptr_q] <= 1'b0;
                        rd_ptr_q        <= rd_ptr_q + C_PTR_ONE;
                        if (w_last) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                    if (w_store) begin
                        occ_q[w_tag]   <= 1'b1;
                        entry_q[w_tag] <= in_entry_i;
                        data_q[w_tag]  <= in_data_i;
                    end
                    if (w_drop) begin
                        err_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
